mgmt_wb_arbiter: RTL and testbench

MGMT_WB_ARBITER -- requirements
Module: mgmt_wb_arbiter

---
 rtl/mgmt_wb_pkg.sv | 21 ++
 rtl/wb_timeout_ctr.sv | 39 +++
 rtl/mgmt_wb_arbiter.sv | 146 ++++++++++++++
 tb/tb_mgmt_wb_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mgmt_wb_pkg.sv
// Shared types and constants for the management Wishbone arbiter.
// The timeout feature is enabled with the WB_TIMEOUT_EN macro.
package mgmt_wb_pkg;

    localparam int WB_ADR_W        = 32;
    localparam int WB_DAT_W        = 32;
    localparam int WB_SEL_W        = 4;
    localparam int TO_CNT_W        = 16;
    localparam int DEFAULT_TIMEOUT = 255;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

    function automatic logic [1:0] grant_of(input arb_state_e s);
        return {s == OWN1, s == OWN0};
    endfunction

endpackage

// File: rtl/wb_timeout_ctr.sv
// Stalled-strobe watchdog: counts enabled cycles and flags expiry at limit-1.
// Built only with WB_TIMEOUT_EN so the default build carries no unused module.
`ifdef WB_TIMEOUT_EN
module wb_timeout_ctr
    import mgmt_wb_pkg::*;
(
    input  logic                core_clk,
    input  logic                core_rst,
    input  logic                enable_i,
    input  logic                clear_i,
    input  logic [TO_CNT_W-1:0] limit_i,
    output logic                expire_o
);

    logic [TO_CNT_W-1:0] cnt_q;
    logic [TO_CNT_W-1:0] cnt_d;

    // An expiry also restarts the count so a persisting stall errors again later.
    assign expire_o = enable_i && !clear_i && (cnt_q == limit_i - TO_CNT_W'(1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i || expire_o) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = cnt_q + TO_CNT_W'(1);
        end
    end

    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`endif

// File: rtl/mgmt_wb_arbiter.sv
// Two-master (CPU data / debug) round-robin arbiter onto the shared mprj Wishbone bus.
// Optional stall watchdog with bus-error return is compiled in with WB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no owner, bus outputs held at 0, next owner picked from cyc requests
// OWN0  | master 0 drives the bus until it drops cyc
// OWN1  | master 1 drives the bus until it drops cyc
module mgmt_wb_arbiter
    import mgmt_wb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
    input  logic                core_clk,
    input  logic                core_rst,

    input  logic                m0_cyc_i,
    input  logic                m0_stb_i,
    input  logic                m0_we_i,
    input  logic [WB_SEL_W-1:0] m0_sel_i,
    input  logic [WB_ADR_W-1:0] m0_adr_i,
    input  logic [WB_DAT_W-1:0] m0_dat_i,
    output logic [WB_DAT_W-1:0] m0_dat_o,
    output logic                m0_ack_o,
    output logic                m0_err_o,

    input  logic                m1_cyc_i,
    input  logic                m1_stb_i,
    input  logic                m1_we_i,
    input  logic [WB_SEL_W-1:0] m1_sel_i,
    input  logic [WB_ADR_W-1:0] m1_adr_i,
    input  logic [WB_DAT_W-1:0] m1_dat_i,
    output logic [WB_DAT_W-1:0] m1_dat_o,
    output logic                m1_ack_o,
    output logic                m1_err_o,

    output logic                mprj_cyc_o,
    output logic                mprj_stb_o,
    output logic                mprj_we_o,
    output logic [WB_SEL_W-1:0] mprj_sel_o,
    output logic [WB_ADR_W-1:0] mprj_adr_o,
    output logic [WB_DAT_W-1:0] mprj_dat_o,
    input  logic                mprj_ack_i,
    input  logic [WB_DAT_W-1:0] mprj_dat_i,

    output logic [1:0]          grant_o,
    output logic                timeout_o
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("mgmt_wb_arbiter: TIMEOUT_CYCLES must be in 1..65535");
    end

    arb_state_e state_q;
    logic       last_grant_q;
    logic       stb_raw;
    logic       expire;

    // last_grant_q holds the index of the master that owned the bus most recently.
    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (m0_cyc_i && (!m1_cyc_i || last_grant_q)) begin
                        state_q <= OWN0;
                    end else if (m1_cyc_i) begin
                        state_q <= OWN1;
                    end
                end
                OWN0: begin
                    if (!m0_cyc_i) begin
                        state_q      <= IDLE;
                        last_grant_q <= 1'b0;
                    end
                end
                OWN1: begin
                    if (!m1_cyc_i) begin
                        state_q      <= IDLE;
                        last_grant_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant_o = grant_of(state_q);

    always_comb begin
        mprj_cyc_o = 1'b0;
        stb_raw    = 1'b0;
        mprj_we_o  = 1'b0;
        mprj_sel_o = '0;
        mprj_adr_o = '0;
        mprj_dat_o = '0;
        m0_dat_o   = '0;
        m0_ack_o   = 1'b0;
        m1_dat_o   = '0;
        m1_ack_o   = 1'b0;
        case (state_q)
            OWN0: begin
                mprj_cyc_o = m0_cyc_i;
                stb_raw    = m0_stb_i;
                mprj_we_o  = m0_we_i;
                mprj_sel_o = m0_sel_i;
                mprj_adr_o = m0_adr_i;
                mprj_dat_o = m0_dat_i;
                m0_dat_o   = mprj_dat_i;
                m0_ack_o   = mprj_ack_i;
            end
            OWN1: begin
                mprj_cyc_o = m1_cyc_i;
                stb_raw    = m1_stb_i;
                mprj_we_o  = m1_we_i;
                mprj_sel_o = m1_sel_i;
                mprj_adr_o = m1_adr_i;
                mprj_dat_o = m1_dat_i;
                m1_dat_o   = mprj_dat_i;
                m1_ack_o   = mprj_ack_i;
            end
            default: ;
        endcase
    end

`ifdef WB_TIMEOUT_EN
    // Ack beats expiry: an acked cycle never enables the counter and always clears it.
    wb_timeout_ctr u_timeout_ctr (
        .core_clk (core_clk),
        .core_rst (core_rst),
        .enable_i (stb_raw && !mprj_ack_i),
        .clear_i  (mprj_ack_i || (state_q == IDLE)),
        .limit_i  (TO_CNT_W'(TIMEOUT_CYCLES)),
        .expire_o (expire)
    );
`else
    assign expire = 1'b0;
`endif

    assign mprj_stb_o = stb_raw && !expire;
    assign m0_err_o   = expire && (state_q == OWN0);
    assign m1_err_o   = expire && (state_q == OWN1);
    assign timeout_o  = expire;

endmodule

// File: tb/tb_mgmt_wb_arbiter.sv
// Self-checking bench for mgmt_wb_arbiter: vector table, directed corner cases
// and a randomized run against a transaction-level ownership model.
module tb_mgmt_wb_arbiter;

    localparam int TCYC = 4;
`ifdef WB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        core_clk = 1'b0;
    logic        core_rst;
    logic        mc [2];
    logic        ms [2];
    logic        mw [2];
    logic [3:0]  msel [2];
    logic [31:0] madr [2];
    logic [31:0] mdat [2];
    logic        ack;
    logic [31:0] sdat;

    logic [31:0] m0_dat_o, m1_dat_o, mprj_adr_o, mprj_dat_o;
    logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
    logic        mprj_cyc_o, mprj_stb_o, mprj_we_o, timeout_o;
    logic [3:0]  mprj_sel_o;
    logic [1:0]  grant_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: who owns the bus, who owned it last, stalled strobes so far.
    int owner = -1;
    int last  = 1;
    int stall = 0;

    always #5 core_clk = ~core_clk;

    mgmt_wb_arbiter #(.TIMEOUT_CYCLES(TCYC)) dut (
        .core_clk   (core_clk),
        .core_rst   (core_rst),
        .m0_cyc_i   (mc[0]),
        .m0_stb_i   (ms[0]),
        .m0_we_i    (mw[0]),
        .m0_sel_i   (msel[0]),
        .m0_adr_i   (madr[0]),
        .m0_dat_i   (mdat[0]),
        .m0_dat_o   (m0_dat_o),
        .m0_ack_o   (m0_ack_o),
        .m0_err_o   (m0_err_o),
        .m1_cyc_i   (mc[1]),
        .m1_stb_i   (ms[1]),
        .m1_we_i    (mw[1]),
        .m1_sel_i   (msel[1]),
        .m1_adr_i   (madr[1]),
        .m1_dat_i   (mdat[1]),
        .m1_dat_o   (m1_dat_o),
        .m1_ack_o   (m1_ack_o),
        .m1_err_o   (m1_err_o),
        .mprj_cyc_o (mprj_cyc_o),
        .mprj_stb_o (mprj_stb_o),
        .mprj_we_o  (mprj_we_o),
        .mprj_sel_o (mprj_sel_o),
        .mprj_adr_o (mprj_adr_o),
        .mprj_dat_o (mprj_dat_o),
        .mprj_ack_i (ack),
        .mprj_dat_i (sdat),
        .grant_o    (grant_o),
        .timeout_o  (timeout_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_clock();
        if (core_rst) begin
            owner = -1;
            last  = 1;
            stall = 0;
        end else if (owner >= 0) begin
            if (TO_EN) begin
                if (ack) stall = 0;
                else if (ms[owner]) stall = (stall == TCYC - 1) ? 0 : stall + 1;
            end
            if (!mc[owner]) begin
                last  = owner;
                owner = -1;
                stall = 0;
            end
        end else begin
            stall = 0;
            if (mc[0] && mc[1]) owner = (last == 1) ? 0 : 1;
            else if (mc[0])     owner = 0;
            else if (mc[1])     owner = 1;
        end
    endtask

    task automatic tick();
        @(posedge core_clk);
        model_clock();
        @(negedge core_clk);
    endtask

    task automatic check_model();
        logic [1:0]  eg;
        logic        ecyc, estb, ewe, eto;
        logic [3:0]  esel;
        logic [31:0] eadr, edat;
        logic [31:0] d0, d1;
        logic        a0, a1, r0, r1;
        eg = 2'b00; ecyc = 0; estb = 0; ewe = 0; eto = 0; esel = 0; eadr = 0; edat = 0;
        d0 = 0; d1 = 0; a0 = 0; a1 = 0; r0 = 0; r1 = 0;
        if (owner >= 0) begin
            eg   = (owner == 0) ? 2'b01 : 2'b10;
            eto  = TO_EN && ms[owner] && !ack && (stall == TCYC - 1);
            ecyc = mc[owner];
            estb = ms[owner] && !eto;
            ewe  = mw[owner];
            esel = msel[owner];
            eadr = madr[owner];
            edat = mdat[owner];
            if (owner == 0) begin d0 = sdat; a0 = ack; r0 = eto; end
            else            begin d1 = sdat; a1 = ack; r1 = eto; end
        end
        chk("grant",     {30'd0, grant_o}, {30'd0, eg});
        chk("mprj_cyc",  {31'd0, mprj_cyc_o}, {31'd0, ecyc});
        chk("mprj_stb",  {31'd0, mprj_stb_o}, {31'd0, estb});
        chk("mprj_we",   {31'd0, mprj_we_o}, {31'd0, ewe});
        chk("mprj_sel",  {28'd0, mprj_sel_o}, {28'd0, esel});
        chk("mprj_adr",  mprj_adr_o, eadr);
        chk("mprj_dat",  mprj_dat_o, edat);
        chk("m0_dat",    m0_dat_o, d0);
        chk("m1_dat",    m1_dat_o, d1);
        chk("m0_ack",    {31'd0, m0_ack_o}, {31'd0, a0});
        chk("m1_ack",    {31'd0, m1_ack_o}, {31'd0, a1});
        chk("m0_err",    {31'd0, m0_err_o}, {31'd0, r0});
        chk("m1_err",    {31'd0, m1_err_o}, {31'd0, r1});
        chk("timeout",   {31'd0, timeout_o}, {31'd0, eto});
    endtask

    task automatic idle_inputs();
        for (int i = 0; i < 2; i++) begin
            mc[i] = 0; ms[i] = 0; mw[i] = 0; msel[i] = 4'h0; madr[i] = 0; mdat[i] = 0;
        end
        ack = 0; sdat = 0;
    endtask

    typedef struct packed {
        logic       rst, c0, c1, ack;
        logic [1:0] grant;
        logic       cyc, a0, a1;
    } vec_t;

    vec_t tbl [18];

    initial begin
        tbl[0]  = '{1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1};
        tbl[14] = '{1'b1, 1'b1, 1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1};
        tbl[15] = '{1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
        tbl[16] = '{1'b0, 1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 1'b1, 1'b0};
        tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0};

        core_rst = 1'b1;
        idle_inputs();
        tick();

        // Requests while reset is held must never produce a grant.
        for (int i = 0; i < 3; i++) begin
            mc[0] = 1; ms[0] = 1; mc[1] = 1; ms[1] = 1;
            #1;
            chk("rst_hold_grant", {30'd0, grant_o}, 32'd0);
            chk("rst_hold_cyc", {31'd0, mprj_cyc_o}, 32'd0);
            tick();
        end

        for (int i = 0; i < 18; i++) begin
            core_rst = tbl[i].rst;
            mc[0] = tbl[i].c0; ms[0] = tbl[i].c0;
            mc[1] = tbl[i].c1; ms[1] = tbl[i].c1;
            ack   = tbl[i].ack;
            sdat  = $urandom;
            #1;
            chk($sformatf("tbl%0d_grant", i), {30'd0, grant_o}, {30'd0, tbl[i].grant});
            chk($sformatf("tbl%0d_cyc", i), {31'd0, mprj_cyc_o}, {31'd0, tbl[i].cyc});
            chk($sformatf("tbl%0d_ack0", i), {31'd0, m0_ack_o}, {31'd0, tbl[i].a0});
            chk($sformatf("tbl%0d_ack1", i), {31'd0, m1_ack_o}, {31'd0, tbl[i].a1});
            tick();
        end
        core_rst = 1'b0;
        idle_inputs();

        // m0 read, slave acks on the third strobe cycle.
        mc[0] = 1; ms[0] = 1; mw[0] = 0; msel[0] = 4'hf; madr[0] = 32'h3000_0000;
        #1; chk("rd_idle_grant", {30'd0, grant_o}, 32'd0); check_model(); tick();
        #1; chk("rd_grant", {30'd0, grant_o}, 32'd1);
        chk("rd_adr", mprj_adr_o, 32'h3000_0000); check_model(); tick();
        #1; chk("rd_noack", {31'd0, m0_ack_o}, 32'd0); check_model(); tick();
        ack = 1; sdat = 32'hDEAD_BEEF;
        #1; chk("rd_dat", m0_dat_o, 32'hDEAD_BEEF);
        chk("rd_ack", {31'd0, m0_ack_o}, 32'd1);
        chk("rd_m1_dat", m1_dat_o, 32'd0);
        chk("rd_m1_ack", {31'd0, m1_ack_o}, 32'd0);
        check_model(); tick();
        idle_inputs();
        #1; check_model(); tick();

        // Reset in the middle of an m0 write, then a tie.
        mc[0] = 1; ms[0] = 1; mw[0] = 1; msel[0] = 4'h3; madr[0] = 32'h3000_0010; mdat[0] = 32'h1234_5678;
        ack = 1;
        #1; check_model(); tick();
        #1; chk("wr_we", {31'd0, mprj_we_o}, 32'd1); chk("wr_dat", mprj_dat_o, 32'h1234_5678);
        check_model(); tick();
        core_rst = 1;
        #1; check_model(); tick();
        core_rst = 0; mc[1] = 1; ms[1] = 1; ack = 0;
        #1; chk("rst_cyc", {31'd0, mprj_cyc_o}, 32'd0); chk("rst_grant", {30'd0, grant_o}, 32'd0);
        check_model(); tick();
        #1; chk("rst_tie_grant", {30'd0, grant_o}, 32'd1); ack = 1; #1; check_model(); tick();
        idle_inputs();
        #1; check_model(); tick();
        #1; check_model(); tick();

        // Long stall on m0.
        mc[0] = 1; ms[0] = 1; madr[0] = 32'h3000_0020;
        #1; check_model(); tick();
        for (int k = 1; k <= 8; k++) begin
            ack = (TO_EN && k == 8);
            #1;
`ifdef WB_TIMEOUT_EN
            chk($sformatf("to_err_%0d", k), {31'd0, m0_err_o}, {31'd0, k == 4});
            chk($sformatf("to_pulse_%0d", k), {31'd0, timeout_o}, {31'd0, k == 4});
            chk($sformatf("to_stb_%0d", k), {31'd0, mprj_stb_o}, {31'd0, k != 4});
            chk($sformatf("to_grant_%0d", k), {30'd0, grant_o}, 32'd1);
            if (k == 8) chk("to_ack_wins", {31'd0, m0_ack_o}, 32'd1);
`else
            chk($sformatf("nto_err_%0d", k), {31'd0, m0_err_o}, 32'd0);
            chk($sformatf("nto_pulse_%0d", k), {31'd0, timeout_o}, 32'd0);
            chk($sformatf("nto_stb_%0d", k), {31'd0, mprj_stb_o}, 32'd1);
`endif
            check_model();
            tick();
        end
        idle_inputs();
        #1; check_model(); tick();

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            core_rst = ($urandom_range(0, 59) == 0);
            for (int i = 0; i < 2; i++) begin
                if ($urandom_range(0, 5) == 0) mc[i] = ~mc[i];
                ms[i]   = mc[i] & ($urandom_range(0, 3) != 0);
                mw[i]   = $urandom_range(0, 1);
                msel[i] = 4'($urandom);
                madr[i] = $urandom;
                mdat[i] = $urandom;
            end
            ack  = ($urandom_range(0, 2) == 0);
            sdat = $urandom;
            #1;
            check_model();
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
